wb_lsu_master: RTL

Load/store bus initiator between the CPU core's memory stage and the Wishbone-style memory responder. Accepts one load or store per valid/ready handshake, checks its encoding, drives a single strobe transaction with the 3-bit size/sign select, waits for ack, and returns read data or an error code. There is exactly one outstanding transaction at a time, and a watchdog aborts hung transfers.

---
 rtl/wb_lsu_master_pkg.sv | 43 ++++
 rtl/wb_lsu_master_watchdog.sv | 39 +++
 rtl/wb_lsu_master.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_lsu_master_pkg.sv
// Shared constants for the load/store Wishbone initiator: funct3/sel codes,
// response error codes, FSM state encoding and the request legality check.
package wb_lsu_master_pkg;

  localparam int unsigned WD_W = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] lsu_err_t;

  localparam lsu_err_t ERR_OK       = 2'b00;
  localparam lsu_err_t ERR_FUNCT3   = 2'b01;
  localparam lsu_err_t ERR_MISALIGN = 2'b10;
  localparam lsu_err_t ERR_TIMEOUT  = 2'b11;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_STROBE   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  // Encoding errors take precedence over alignment; halfwords may straddle words.
  function automatic lsu_err_t lsu_check(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    lsu_err_t err;
    err = ERR_OK;
    case (funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: err = ERR_OK;
      default:                        err = ERR_FUNCT3;
    endcase
    if ((err == ERR_OK) && we && funct3[2]) begin
      err = ERR_FUNCT3;
    end
    if ((err == ERR_OK) && (funct3 == F3_W) && (addr_lo != 2'b00)) begin
      err = ERR_MISALIGN;
    end
    return err;
  endfunction

endpackage

// File: rtl/wb_lsu_master_watchdog.sv
// Loadable saturating cycle counter; flags expiry on the cycle that would
// complete TIMEOUT_CYCLES counted cycles.
module wb_watchdog
  import wb_lsu_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] CMAX  = '1;

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != CMAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_enable && (cnt_q >= LIMIT);

endmodule

// File: rtl/wb_lsu_master.sv
// Single-outstanding load/store initiator: CPU valid/ready request in,
// one Wishbone strobe out, registered response with error code back.
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_err,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_sel,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);

  logic [1:0]  state_q, state_d;
  logic        wb_stb_q, wb_stb_d;
  logic [31:0] wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_we_q, wb_we_d;
  logic [2:0]  wb_sel_q, wb_sel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  lsu_err_t    rsp_err_q, rsp_err_d;

  lsu_err_t    req_err;
  logic        wd_clear;
  logic        wd_enable;
  logic        wd_expired;

  assign req_err   = lsu_check(i_req_we, i_req_funct3, i_req_addr[1:0]);
  assign wd_enable = (state_q == ST_STROBE) || (state_q == ST_WAIT_ACK);

  wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (wd_clear),
    .i_enable  (wd_enable),
    .o_expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    wb_stb_d    = wb_stb_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    wb_sel_d    = wb_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wd_clear    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          wb_addr_d = i_req_addr;
          wb_data_d = i_req_wdata;
          wb_we_d   = i_req_we;
          wb_sel_d  = i_req_funct3;
          if (req_err != ERR_OK) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_rdata_d = '0;
          end else begin
            state_d  = ST_STROBE;
            wb_stb_d = 1'b1;
            wd_clear = 1'b1;
          end
        end
      end

      ST_STROBE: begin
        // An ack only counts once the strobe has been taken (no stall).
        if (!i_wb_stall && i_wb_ack) begin
          state_d     = ST_RESP;
          wb_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = wb_we_q ? 32'd0 : i_wb_data;
        end else if (wd_expired) begin
          state_d     = ST_RESP;
          wb_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = '0;
        end else if (!i_wb_stall) begin
          state_d  = ST_WAIT_ACK;
          wb_stb_d = 1'b0;
        end
      end

      ST_WAIT_ACK: begin
        if (i_wb_ack) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = wb_we_q ? 32'd0 : i_wb_data;
        end else if (wd_expired) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = '0;
        end
      end

      default: begin
        if (i_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      wb_stb_q    <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_sel_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      wb_stb_q    <= wb_stb_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_sel_q    <= wb_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_wb_stb    = wb_stb_q;
  assign o_wb_addr   = wb_addr_q;
  assign o_wb_data   = wb_data_q;
  assign o_wb_we     = wb_we_q;
  assign o_wb_sel    = wb_sel_q;

endmodule
